// File: rtl/noc_endp_injector_pkg.sv
// rtl/noc_endp_injector_pkg.sv - shared NoC configuration, flit layout and injector FSM states
package noc_endp_injector_pkg;

    typedef enum logic [1:0] {
        INJ_IDLE = 2'd0,
        INJ_HEAD = 2'd1,
        INJ_BODY = 2'd2
    } inj_state_t;

    // Per-instance NoC configuration table, indexed by NOC_ID.
    function automatic int noc_v(input int noc_id);
        case (noc_id)
            1:       return 4;
            default: return 2;
        endcase
    endfunction

    function automatic int noc_fpay(input int noc_id);
        case (noc_id)
            1:       return 64;
            default: return 32;
        endcase
    endfunction

    function automatic int noc_raw(input int noc_id);
        case (noc_id)
            1:       return 6;
            default: return 8;
        endcase
    endfunction

    function automatic int noc_vw(input int noc_id);
        return (noc_v(noc_id) > 1) ? $clog2(noc_v(noc_id)) : 1;
    endfunction

    // Flit = {hdr, tail, vc one-hot[V], payload[Fpay]}
    function automatic int noc_fw(input int noc_id);
        return noc_fpay(noc_id) + noc_v(noc_id) + 2;
    endfunction

    function automatic int flit_hdr_pos(input int noc_id);
        return noc_fw(noc_id) - 1;
    endfunction

    function automatic int flit_tail_pos(input int noc_id);
        return noc_fw(noc_id) - 2;
    endfunction

    function automatic int flit_vc_lsb(input int noc_id);
        return noc_fpay(noc_id);
    endfunction

    function automatic int flit_pay_lsb(input int noc_id);
        return (noc_id >= 0) ? 0 : 0;
    endfunction

    localparam int NOC0_V  = noc_v(0);
    localparam int NOC0_FW = noc_fw(0);

    typedef struct packed {
        logic               flit_wr;
        logic [NOC0_FW-1:0] flit;
        logic [NOC0_V-1:0]  credit;
    } smartflit_chanel_t;

endpackage

// File: rtl/noc_credit_counter.sv
// rtl/noc_credit_counter.sv - per-VC credit counter, saturating at the buffer depth
module noc_credit_counter #(
    parameter  int B  = 4,
    localparam int CW = $clog2(B + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_dec,
    input  logic          i_inc,
    output logic [CW-1:0] o_count,
    output logic          o_overflow
);

    localparam logic [CW-1:0] FULL = CW'(B);

    logic [CW-1:0] r_count;

    // A return with no matching consumption while already full is a router protocol error.
    assign o_overflow = i_inc && !i_dec && (r_count == FULL);
    assign o_count    = r_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= FULL;
        end else if (i_inc && !i_dec && (r_count != FULL)) begin
            r_count <= r_count + CW'(1);
        end else if (i_dec && !i_inc && (r_count != '0)) begin
            r_count <= r_count - CW'(1);
        end
    end

endmodule

// File: rtl/noc_endp_injector.sv
// rtl/noc_endp_injector.sv - endpoint packet injector: descriptor + payload in, credited flits out
module noc_endp_injector
    import noc_endp_injector_pkg::*;
#(
    parameter  int NOC_ID      = 0,
    parameter  int B           = 4,
    parameter  int MAX_PKT_LEN = 16,
    parameter  int SRC_ADDR    = 0,
    localparam int V           = noc_v(NOC_ID),
    localparam int VW          = noc_vw(NOC_ID),
    localparam int FPAY        = noc_fpay(NOC_ID),
    localparam int RAW         = noc_raw(NOC_ID),
    localparam int FW          = noc_fw(NOC_ID),
    localparam int LENW        = $clog2(MAX_PKT_LEN + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            pkt_valid,
    output logic            pkt_ready,
    input  logic [RAW-1:0]  pkt_dest,
    input  logic [VW-1:0]   pkt_vc,
    input  logic [LENW-1:0] pkt_len,
    input  logic            pay_valid,
    output logic            pay_ready,
    input  logic [FPAY-1:0] pay_data,
    output logic            flit_wr,
    output logic [FW-1:0]   flit_out,
    input  logic [V-1:0]    credit_in,
    output logic            busy,
    output logic [1:0]      err
);

    localparam int CW       = $clog2(B + 1);
    localparam int HDR_POS  = flit_hdr_pos(NOC_ID);
    localparam int TAIL_POS = flit_tail_pos(NOC_ID);
    localparam int VC_LSB   = flit_vc_lsb(NOC_ID);
    localparam int PAY_LSB  = flit_pay_lsb(NOC_ID);

    localparam logic [LENW-1:0] MAX_LEN_L = LENW'(MAX_PKT_LEN);
    localparam logic [LENW-1:0] ONE_L     = LENW'(1);
    localparam logic [RAW-1:0]  SRC_L     = RAW'(SRC_ADDR);

    inj_state_t      r_state;
    logic [RAW-1:0]  r_dest;
    logic [VW-1:0]   r_vc;
    logic [LENW-1:0] r_len;
    logic [LENW-1:0] r_cnt;
    logic            r_flit_wr;
    logic [FW-1:0]   r_flit_out;
    logic [1:0]      r_err;

    logic [CW-1:0]   w_credit [V];
    logic [V-1:0]    w_credit_ok;
    logic [V-1:0]    w_dec;
    logic [V-1:0]    w_ovf;
    logic [V-1:0]    w_vc_onehot;
    logic            w_has_credit;
    logic            w_accept;
    logic            w_len_bad;
    logic            w_head_go;
    logic            w_body_go;
    logic            w_issue;
    logic            w_tail_head;
    logic            w_tail_body;
    logic [FPAY-1:0] w_head_pay;
    logic [FW-1:0]   w_flit_next;

    genvar gv;
    generate
        for (gv = 0; gv < V; gv++) begin : g_vc
            noc_credit_counter #(.B(B)) u_credit (
                .clk        (clk),
                .reset      (reset),
                .i_dec      (w_dec[gv]),
                .i_inc      (credit_in[gv]),
                .o_count    (w_credit[gv]),
                .o_overflow (w_ovf[gv])
            );
            assign w_credit_ok[gv] = (w_credit[gv] != '0);
        end
    endgenerate

    assign w_vc_onehot  = V'(1) << r_vc;
    assign w_has_credit = w_credit_ok[r_vc];

    // Readiness is gated by reset itself so nothing is advertised while held in reset.
    assign pkt_ready = reset && (r_state == INJ_IDLE);
    assign pay_ready = (r_state == INJ_BODY) && w_has_credit;
    assign busy      = (r_state != INJ_IDLE);
    assign flit_wr   = r_flit_wr;
    assign flit_out  = r_flit_out;
    assign err       = r_err;

    assign w_accept    = pkt_valid && pkt_ready;
    assign w_len_bad   = (pkt_len == '0) || (pkt_len > MAX_LEN_L);
    assign w_head_go   = (r_state == INJ_HEAD) && w_has_credit;
    assign w_body_go   = (r_state == INJ_BODY) && w_has_credit && pay_valid;
    assign w_issue     = w_head_go || w_body_go;
    assign w_tail_head = (r_len == ONE_L);
    assign w_tail_body = (r_cnt == (r_len - ONE_L));
    assign w_head_pay  = FPAY'({r_dest, SRC_L});
    assign w_dec       = w_issue ? w_vc_onehot : '0;

    always_comb begin
        w_flit_next                    = '0;
        w_flit_next[HDR_POS]           = w_head_go;
        w_flit_next[TAIL_POS]          = w_head_go ? w_tail_head : w_tail_body;
        w_flit_next[VC_LSB +: V]       = w_vc_onehot;
        w_flit_next[PAY_LSB +: FPAY]   = w_head_go ? w_head_pay : pay_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= INJ_IDLE;
            r_dest     <= '0;
            r_vc       <= '0;
            r_len      <= '0;
            r_cnt      <= '0;
            r_flit_wr  <= 1'b0;
            r_flit_out <= '0;
            r_err      <= '0;
        end else begin
            r_flit_wr <= w_issue;
            if (w_issue) begin
                r_flit_out <= w_flit_next;
            end
            if (|w_ovf) begin
                r_err[1] <= 1'b1;
            end
            case (r_state)
                INJ_IDLE: begin
                    if (w_accept) begin
                        r_dest  <= pkt_dest;
                        r_vc    <= pkt_vc;
                        r_len   <= w_len_bad ? ONE_L : pkt_len;
                        r_state <= INJ_HEAD;
                        if (w_len_bad) begin
                            r_err[0] <= 1'b1;
                        end
                    end
                end
                INJ_HEAD: begin
                    if (w_head_go) begin
                        r_cnt   <= ONE_L;
                        r_state <= w_tail_head ? INJ_IDLE : INJ_BODY;
                    end
                end
                INJ_BODY: begin
                    if (w_body_go) begin
                        r_cnt <= r_cnt + ONE_L;
                        if (w_tail_body) begin
                            r_state <= INJ_IDLE;
                        end
                    end
                end
                default: r_state <= INJ_IDLE;
            endcase
        end
    end

endmodule
